// File: rtl/toggle_counter.sv
// toggle_counter: WIDTH-bit bank of T flip-flops that can also act as a
// modulo up/down counter or a loadable register, with a registered
// terminal-count flag for chaining.
// Ports: clk, reset (sync, active-high), en, mode[1:0]
// (00 toggle, 01 up, 10 down, 11 load), t (toggle mask), d (load value),
// q (register value), tc (terminal count, registered).
// Optional: define TOGGLE_COUNTER_GRAY_EN to add q_gray, a registered
// Gray-code copy of q that is cycle-aligned with q.
module toggle_counter #(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MODULUS  = 256,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] d,
`ifdef TOGGLE_COUNTER_GRAY_EN
    output logic [WIDTH-1:0] q_gray,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("toggle_counter: WIDTH must be 1..32");
    end

    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_mod
        $error("toggle_counter: MODULUS must be 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO  = '0;

    // Value taken at a boundary: wrap to the far end, or hold.
    localparam logic [WIDTH-1:0] UP_BND = SATURATE ? MAX_V : ZERO;
    localparam logic [WIDTH-1:0] DN_BND = SATURATE ? ZERO : MAX_V;

    localparam logic [1:0] M_TGL  = 2'b00;
    localparam logic [1:0] M_UP   = 2'b01;
    localparam logic [1:0] M_DOWN = 2'b10;
    localparam logic [1:0] M_LOAD = 2'b11;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tc_q;
    logic             tc_d;

    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (en) begin
            unique case (mode)
                M_TGL: begin
                    q_d = q_q ^ t;
                end
                M_UP: begin
                    // Any value at or past MAX_V is a boundary,
                    // including out-of-range values left by toggle.
                    if (q_q < MAX_V) begin
                        q_d = q_q + ONE;
                    end else begin
                        q_d  = UP_BND;
                        tc_d = 1'b1;
                    end
                end
                M_DOWN: begin
                    if (q_q != ZERO) begin
                        q_d = q_q - ONE;
                    end else begin
                        q_d  = DN_BND;
                        tc_d = 1'b1;
                    end
                end
                M_LOAD: begin
                    q_d = (d <= MAX_V) ? d : MAX_V;
                end
                default: begin
                    q_d = q_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign q  = q_q;
    assign tc = tc_q;

`ifdef TOGGLE_COUNTER_GRAY_EN
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;

    // Encode the next value so gray_q lands on the same edge as q_q.
    always_comb begin
        gray_d = (q_d >> 1) ^ q_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gray_q <= '0;
        end else begin
            gray_q <= gray_d;
        end
    end

    assign q_gray = gray_q;
`endif

endmodule

// File: tb/tb_toggle_counter.sv
// tb_toggle_counter: directed bench for toggle_counter with two
// instances (MODULUS=10, wrapping and saturating) sharing one stimulus.
module tb_toggle_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [7:0] t;
    logic [7:0] d;
    logic [7:0] q_w;
    logic       tc_w;
    logic [7:0] q_s;
    logic       tc_s;
`ifdef TOGGLE_COUNTER_GRAY_EN
    logic [7:0] g_w;
    logic [7:0] g_s;
`endif

    int n_checks;
    int n_fails;

    toggle_counter #(
        .WIDTH(8), .MODULUS(10), .SATURATE(1'b0)
    ) u_wrap (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .t(t), .d(d),
`ifdef TOGGLE_COUNTER_GRAY_EN
        .q_gray(g_w),
`endif
        .q(q_w), .tc(tc_w)
    );

    toggle_counter #(
        .WIDTH(8), .MODULUS(10), .SATURATE(1'b1)
    ) u_sat (
        .clk(clk), .reset(reset), .en(en), .mode(mode),
        .t(t), .d(d),
`ifdef TOGGLE_COUNTER_GRAY_EN
        .q_gray(g_s),
`endif
        .q(q_s), .tc(tc_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic e,
                        input logic [1:0] m,
                        input logic [7:0] tv,
                        input logic [7:0] dv);
        reset = r;
        en    = e;
        mode  = m;
        t     = tv;
        d     = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp8(input string tag,
                        input logic [7:0] obs,
                        input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmp1(input string tag,
                        input logic obs,
                        input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag,
                         input logic [7:0] eqw, input logic etw,
                         input logic [7:0] eqs, input logic ets);
        cmp8({tag, " q_wrap"}, q_w, eqw);
        cmp1({tag, " tc_wrap"}, tc_w, etw);
        cmp8({tag, " q_sat"}, q_s, eqs);
        cmp1({tag, " tc_sat"}, tc_s, ets);
`ifdef TOGGLE_COUNTER_GRAY_EN
        cmp8({tag, " gray_wrap"}, g_w, (eqw >> 1) ^ eqw);
        cmp8({tag, " gray_sat"}, g_s, (eqs >> 1) ^ eqs);
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        reset = 1'b0;
        en    = 1'b0;
        mode  = 2'b00;
        t     = 8'h00;
        d     = 8'h00;
        #2;

        // Reset, scramble via toggle, reset overriding en/mode
        step(1, 0, 2'b00, 8'h00, 8'h00);
        check("rst0", 8'h00, 0, 8'h00, 0);
        step(0, 1, 2'b00, 8'h3C, 8'h00);
        check("scramble", 8'h3C, 0, 8'h3C, 0);
        step(1, 1, 2'b00, 8'hFF, 8'h00);
        check("rst1", 8'h00, 0, 8'h00, 0);

        // Toggle A5 twice
        step(0, 1, 2'b00, 8'hA5, 8'h00);
        check("tgl1", 8'hA5, 0, 8'hA5, 0);
        step(0, 1, 2'b00, 8'hA5, 8'h00);
        check("tgl2", 8'h00, 0, 8'h00, 0);

        // Up from 8
        step(0, 1, 2'b11, 8'h00, 8'd8);
        check("ld8", 8'd8, 0, 8'd8, 0);
        step(0, 1, 2'b01, 8'h00, 8'h00);
        check("up1", 8'd9, 0, 8'd9, 0);
        step(0, 1, 2'b01, 8'h00, 8'h00);
        check("up2", 8'd0, 1, 8'd9, 1);
        step(0, 1, 2'b01, 8'h00, 8'h00);
        check("up3", 8'd1, 0, 8'd9, 1);

        // Down from 1
        step(0, 1, 2'b11, 8'h00, 8'd1);
        check("ld1", 8'd1, 0, 8'd1, 0);
        step(0, 1, 2'b10, 8'h00, 8'h00);
        check("dn1", 8'd0, 0, 8'd0, 0);
        step(0, 1, 2'b10, 8'h00, 8'h00);
        check("dn2", 8'd9, 1, 8'd0, 1);
        step(0, 1, 2'b10, 8'h00, 8'h00);
        check("dn3", 8'd8, 0, 8'd0, 1);

        // Load clamp, then disable
        step(0, 1, 2'b11, 8'h00, 8'd15);
        check("clamp", 8'd9, 0, 8'd9, 0);
        step(0, 0, 2'b01, 8'h00, 8'h00);
        check("hold1", 8'd9, 0, 8'd9, 0);
        step(0, 0, 2'b01, 8'h00, 8'h00);
        check("hold2", 8'd9, 0, 8'd9, 0);

        // tc drops when en falls after a boundary
        step(0, 1, 2'b01, 8'h00, 8'h00);
        check("bnd", 8'd0, 1, 8'd9, 1);
        step(0, 0, 2'b01, 8'hFF, 8'hFF);
        check("en_off", 8'd0, 0, 8'd9, 0);

        // Out-of-range value from toggle
        step(0, 1, 2'b11, 8'h00, 8'd0);
        check("ld0", 8'd0, 0, 8'd0, 0);
        step(0, 1, 2'b00, 8'hF0, 8'h00);
        check("tglF0", 8'hF0, 0, 8'hF0, 0);
        step(0, 1, 2'b10, 8'h00, 8'h00);
        check("dn_oor", 8'hEF, 0, 8'hEF, 0);
        step(0, 1, 2'b01, 8'h00, 8'h00);
        check("up_oor", 8'd0, 1, 8'd9, 1);

        // Reset mid-count
        step(0, 1, 2'b11, 8'h00, 8'd5);
        check("ld5", 8'd5, 0, 8'd5, 0);
        step(1, 1, 2'b01, 8'h00, 8'h00);
        check("rst_mid", 8'd0, 0, 8'd0, 0);
        step(0, 1, 2'b01, 8'h00, 8'h00);
        check("post_rst", 8'd1, 0, 8'd1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/toggle_counter.md
Name: toggle_counter

Overview:
- Parametrised successor to the single-bit toggle flip-flop: a WIDTH-bit register of toggle cells with a selectable operating mode.
- Modes: per-bit masked toggle, modulo up-count, modulo down-count, parallel load.
- Registered terminal-count flag for chaining counters and timers.
- General-purpose building block for the flip_flops/counters area; used wherever a bank of T flip-flops or a small modulo counter is needed.

Parameters:
WIDTH, 8, register width in bits (1..32)
MODULUS, 256, count range 0..MODULUS-1; legal range 2..2^WIDTH
SATURATE, 0, 0 = wrap at boundary, 1 = hold at boundary

Ports:
clk  input  1  clock, rising-edge active
reset  input  1  synchronous, active-high reset
en  input  1  operation enable; mode is ignored when low
mode  input  2  00 toggle, 01 count up, 10 count down, 11 load
t  input  WIDTH  per-bit toggle mask (mode 00 only)
d  input  WIDTH  load value (mode 11 only)
q  output  WIDTH  register value
tc  output  1  terminal-count flag, registered

Behaviour:
- Interface: one clock `clk`; reset is `reset`, synchronous and active-high. All state changes on the rising edge of `clk`.
- Reset: q=0, tc=0 on the first rising edge with reset=1. Reset overrides en and mode. Reset mid-count discards the current value. There is no initial-block dependence; reset is mandatory.
- Priority: reset > en. With en=0: q holds, tc<=0.
- Mode 00 (toggle): q <= q ^ t. Each bit behaves as an independent T flip-flop.
  - No modulus check; q may take any WIDTH-bit value. tc<=0.
- Mode 01 (up):
  - If q < MODULUS-1: q <= q+1, tc<=0.
  - Else (boundary, including q > MODULUS-1 from toggle mode): SATURATE=0 gives q<=0; SATURATE=1 gives q<=MODULUS-1. tc<=1 in both cases.
- Mode 10 (down):
  - If q != 0: q <= q-1. If q > MODULUS-1, it still decrements by 1. tc<=0.
  - If q == 0: SATURATE=0 gives q<=MODULUS-1; SATURATE=1 gives q<=0. tc<=1.
- Mode 11 (load): q <= d when d <= MODULUS-1, else q <= MODULUS-1 (clamp). tc<=0.
- tc timing: high for the single cycle after each enabled boundary event. While saturated and still counting into the boundary, tc stays high every cycle.
- Latency: one clock from en/mode/t/d sample to q and tc update. No combinational path from inputs to outputs.
- Mode change takes effect on the next edge. No pipeline state carries across a mode change.
- Arithmetic is WIDTH-bit unsigned. MODULUS=2^WIDTH gives natural binary wrap. The comparison against MODULUS-1 uses a constant of WIDTH bits.
- Illegal MODULUS (<2 or >2^WIDTH): elaboration-time error.

Optional Feature:
- Macro: TOGGLE_COUNTER_GRAY_EN.
- Defined: adds output port q_gray (WIDTH) = (q >> 1) ^ q.
  - Held in its own register, updated on the same edge as q, so it is cycle-aligned with q. Reset value 0.
- Undefined: q_gray port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset: drive random q via mode 00, then reset=1 for one edge -> q=0, tc=0, and q_gray=0 if the macro is enabled.
- Toggle: WIDTH=8, q=0, en=1, mode=00, t=8'hA5 for 2 edges -> q=8'hA5, then 8'h00; tc=0 throughout.
- Up wrap: MODULUS=10, SATURATE=0, load 8, then mode=01 for 3 edges -> q=9, 0, 1; tc=0, 1, 0.
- Down saturate: MODULUS=10, SATURATE=1, load 1, then mode=10 for 3 edges -> q=0, 0, 0; tc=0, 1, 1.
- Load clamp and enable: MODULUS=10, mode=11, d=15 -> q=9. Then en=0, mode=01 for 2 edges -> q=9, tc=0.
- Reset mid-count: counting up at q=5, reset=1 with en=1, mode=01 -> q=0 next edge. Release reset -> q=1 on the following edge.
